mem_copy_engine: RTL
====================

# mem_copy_engine

Block-transfer engine that sits directly upstream of the 64K×16 word memory and drives its write port and asynchronous read port. On a start pulse it either copies a block of words from a source region to a destination region (memmove semantics, overlap-safe) or fills a destination region with a constant, moving one word per clock. It gives the system a single-command way to clear, initialise or relocate memory regions without a processor loop.

## Interface
- ADDRESS_WIDTH, 16, width of all addresses and of Length; address arithmetic is modulo 2^ADDRESS_WIDTH
- DATA_WIDTH, 16, memory word width

- Clock  input  1  single clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  command strobe, sampled only in IDLE
- Mode  input  1  0 = copy, 1 = fill; captured with Start
- Source_Address  input  ADDRESS_WIDTH  copy source base; captured with Start, ignored in fill
- Destination_Address  input  ADDRESS_WIDTH  destination base; captured with Start
- Length  input  ADDRESS_WIDTH  word count; 0 = no transfer
- Fill_Value  input  DATA_WIDTH  fill word; captured with Start
- Abort  input  1  terminate the running transfer
- Busy  output  1  high in RUN
- Done  output  1  one-cycle completion pulse
- Aborted  output  1  valid with Done; 1 if the transfer was cut short
- Mem_Write_Enable  output  1  to memory write enable
- Mem_Write_Address  output  ADDRESS_WIDTH  to memory write address
- Mem_Write_Data  output  DATA_WIDTH  to memory write data
- Mem_Read_Address  output  ADDRESS_WIDTH  to memory read address
- Mem_Read_Data  input  DATA_WIDTH  from memory, combinational for Mem_Read_Address

## Operation
- States: IDLE, RUN, DONE.
- IDLE: Start=1 captures Mode, Fill_Value, Length and both addresses into registers. Length≠0 -> RUN; Length=0 -> DONE (no writes). Start outside IDLE ignored, including during DONE.
- Direction (copy only): descending when 0 < (Destination_Address − Source_Address) mod 2^AW < Length, else ascending. Fill is always ascending.
- Ascending: pointers start at base, increment each RUN cycle. Descending: pointers start at base+Length−1 (mod 2^AW), decrement.
- RUN, every cycle: Mem_Write_Enable=1, Mem_Write_Address=dst pointer, Mem_Read_Address=src pointer, Mem_Write_Data = Fill_Value (fill) or Mem_Read_Data (copy). Remaining counter decrements; at 1 -> DONE.
- Pointers wrap modulo 2^AW (e.g. 0xFFFF+1 = 0x0000).
- Src == Dst copy: performs Length rewrites of identical data; legal.
- Abort=1 in a RUN cycle: that cycle's write still occurs; next state DONE with Aborted=1. Abort on the final cycle yields Aborted=1. Abort outside RUN ignored.
- DONE: Done=1 for one cycle, Aborted valid, -> IDLE.
- Outside RUN: Mem_Write_Enable=0; Mem_Read_Address and Mem_Write_Address hold current pointer values.

## Timing
- Reset: state IDLE; Busy, Done, Aborted, Mem_Write_Enable = 0; address/data registers = 0; Mem_Write_Data = 0 when not in RUN. Reset mid-RUN stops writes immediately (asynchronously); no Done pulse.
- Start sampled at edge k, Length=L>0: Busy and Mem_Write_Enable high cycles k+1..k+L; Done high in cycle k+L+1; IDLE from k+L+2; next Start accepted at edge k+L+2.
- Length=0: Done high in cycle k+1, no write cycles.
- Throughput 1 word/clock; write commits at the rising edge ending each RUN cycle. Copy relies on same-cycle combinational read data.
- All outputs derived from registered state; no combinational path from Start/Abort to memory outputs.

## Test plan
- Fill: Mode=1, Dst=0x0100, L=4, Fill=0xA5A5 -> writes 0x0100–0x0103 in cycles k+1..k+4, Done at k+5, Aborted=0, 0x0104 untouched.
- Ascending copy: mem[0x10..0x13]=1,2,3,4; Src=0x10, Dst=0x20, L=4 -> mem[0x20..0x23]=1,2,3,4, source unchanged.
- Overlap descending: mem[0x10..0x13]=1,2,3,4; Src=0x10, Dst=0x12, L=4 -> write order 0x15,0x14,0x13,0x12; mem[0x12..0x15]=1,2,3,4.
- Wrap: fill Dst=0xFFFE, L=4, Fill=0x1234 -> writes 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Abort/zero length: L=8, Abort in third RUN cycle -> exactly 3 writes, Done+Aborted=1 next cycle; separately L=0 -> Done next cycle, zero writes, Start during DONE ignored.
- Reset mid-RUN: assert Reset during cycle k+2 of L=6 fill -> Busy and Mem_Write_Enable drop at once, no Done, new Start after release accepted normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block-transfer engine for a word memory: overlap-safe copy (memmove) or
// constant fill, one word per clock, driving the memory's write and async read ports.
module mem_copy_engine #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [ADDRESS_WIDTH-1:0] i_source_address,
    input  logic [ADDRESS_WIDTH-1:0] i_destination_address,
    input  logic [ADDRESS_WIDTH-1:0] i_length,
    input  logic [DATA_WIDTH-1:0]    i_fill_value,
    input  logic                     i_abort,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_aborted,
    output logic                     o_mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] o_mem_write_address,
    output logic [DATA_WIDTH-1:0]    o_mem_write_data,
    output logic [ADDRESS_WIDTH-1:0] o_mem_read_address,
    input  logic [DATA_WIDTH-1:0]    i_mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                   r_state;
    logic                     r_mode;
    logic                     r_descend;
    logic [DATA_WIDTH-1:0]    r_fill_value;
    logic [ADDRESS_WIDTH-1:0] r_src_ptr;
    logic [ADDRESS_WIDTH-1:0] r_dst_ptr;
    logic [ADDRESS_WIDTH-1:0] r_remaining;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_aborted;
    logic                     r_we;

    logic [ADDRESS_WIDTH-1:0] w_diff;
    logic [ADDRESS_WIDTH-1:0] w_last_offset;
    logic [ADDRESS_WIDTH-1:0] w_step;
    logic                     w_descend;

    // A copy must run backwards when the destination starts inside the source
    // block, otherwise the first writes would clobber source words not yet read.
    assign w_diff        = i_destination_address - i_source_address;
    assign w_descend     = !i_mode && (w_diff != '0) && (w_diff < i_length);
    assign w_last_offset = i_length - ADDRESS_WIDTH'(1);
    assign w_step        = r_descend ? '1 : ADDRESS_WIDTH'(1);

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_mode       <= 1'b0;
            r_descend    <= 1'b0;
            r_fill_value <= '0;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_remaining  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_we         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mode       <= i_mode;
                        r_descend    <= w_descend;
                        r_fill_value <= i_fill_value;
                        r_remaining  <= i_length;
                        r_aborted    <= 1'b0;
                        r_src_ptr    <= w_descend ? i_source_address + w_last_offset
                                                  : i_source_address;
                        r_dst_ptr    <= w_descend ? i_destination_address + w_last_offset
                                                  : i_destination_address;
                        if (i_length == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_we    <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    r_src_ptr   <= r_src_ptr + w_step;
                    r_dst_ptr   <= r_dst_ptr + w_step;
                    r_remaining <= r_remaining - ADDRESS_WIDTH'(1);
                    if (i_abort || (r_remaining == ADDRESS_WIDTH'(1))) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_we      <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= i_abort;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Copy data is the memory's same-cycle async read of the source pointer.
    assign o_mem_write_data    = r_we ? (r_mode ? r_fill_value : i_mem_read_data) : '0;
    assign o_mem_write_enable  = r_we;
    assign o_mem_write_address = r_dst_ptr;
    assign o_mem_read_address  = r_src_ptr;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_aborted           = r_aborted;

endmodule
